// File: rtl/mw8080_inputs.sv
// mw8080 arcade input conditioning: shared-prescaler debouncing of all raw
// switches, per-player control remapping (swap, rotate, autofire) and
// per-slot coin pulse stretching with a wrapping coin counter.

// Per-player remap: rotate directions, then apply autofire to fireA.
// Bit order {fireB,fireA,up,down,left,right}.
module mw8080_player_map (
  input  logic [5:0] btn_in,
  input  logic       rotate,
  input  logic       af_en,
  input  logic       af_phase,
  output logic [5:0] btn_out
);
  logic [5:0] rot;

  // 90 deg clockwise: up<-right, right<-down, down<-left, left<-up.
  always_comb begin
    rot = btn_in;
    if (rotate) begin
      rot[3] = btn_in[0];
      rot[0] = btn_in[2];
      rot[2] = btn_in[1];
      rot[1] = btn_in[3];
    end
  end

  // Autofire replaces a held fireA with the shared square wave.
  always_comb begin
    btn_out = rot;
    if (af_en && rot[4]) btn_out[4] = af_phase;
  end
endmodule

// One coin slot: IDLE -> PULSE (fixed width) -> HOLD (until released) -> IDLE.
module mw8080_coin_slot #(
  parameter int COIN_CYCLES = 100000
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic coin_db,
  output logic pulse,
  output logic enter
);
  localparam int CW = (COIN_CYCLES > 1) ? $clog2(COIN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          coin_q;
  logic          rise;
  logic          last;

  assign rise = coin_db & ~coin_q;
  assign last = (cnt == CW'(COIN_CYCLES - 1));

  // State, pulse-width counter, edge history and registered pulse output.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      coin_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      state  <= state_nxt;
      coin_q <= coin_db;
      pulse  <= (state_nxt == PULSE);
      if (state == PULSE && !last) cnt <= cnt + 1'b1;
      else                         cnt <= '0;
    end
  end

  // Edges are only honoured in IDLE, so a held or bouncing coin never retriggers.
  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    case (state)
      IDLE:  if (rise) begin
               state_nxt = PULSE;
               enter     = 1'b1;
             end
      PULSE: if (last) state_nxt = coin_db ? HOLD : IDLE;
      HOLD:  if (!coin_db) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// Top level.
module mw8080_inputs #(
  parameter int NUM_PLAYERS = 2,
  parameter int DB_CYCLES   = 1024,
  parameter int COIN_CYCLES = 100000,
  parameter int AF_HALF     = 200000,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [6*NUM_PLAYERS-1:0] joy_in,
  input  logic [NUM_PLAYERS-1:0]   coin_in,
  input  logic [NUM_PLAYERS-1:0]   start_in,
  input  logic                     rotate,
  input  logic                     joyswap,
  input  logic [NUM_PLAYERS-1:0]   autofire_en,
  output logic [6*NUM_PLAYERS-1:0] player_out,
  output logic [NUM_PLAYERS-1:0]   coin_out,
  output logic [NUM_PLAYERS-1:0]   start_out,
  output logic [7:0]               coin_count
);
  localparam int   NP    = NUM_PLAYERS;
  localparam int   RAW_W = 8 * NP;
  localparam int   PW    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int   AW    = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;
  localparam logic INV   = (ACTIVE_LOW != 0);

  // ---------------- sample prescaler ----------------
  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PW'(DB_CYCLES - 1));

  // Free-running divider producing the shared debounce sample tick.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // ---------------- debounce ----------------
  // Sample window per bit is the sample taken on this tick plus the two
  // stored from the previous ticks; a bit updates only when all three agree.
  logic [RAW_W-1:0] raw, smp0, smp1, db, stable;

  assign raw    = {coin_in, start_in, joy_in};
  assign stable = ~(raw ^ smp0) & ~(raw ^ smp1);

  // Shift the sample history and latch agreeing bits on each tick.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      smp0 <= '0;
      smp1 <= '0;
      db   <= '0;
    end else if (tick) begin
      smp0 <= raw;
      smp1 <= smp0;
      db   <= (db & ~stable) | (raw & stable);
    end
  end

  logic [NP-1:0][5:0] joy_db, joy_sw, joy_map, player_q;
  logic [NP-1:0]      start_db, coin_db;

  assign joy_db   = db[6*NP-1:0];
  assign start_db = db[7*NP-1:6*NP];
  assign coin_db  = db[8*NP-1:7*NP];

  // ---------------- autofire square wave ----------------
  logic [AW-1:0] af_cnt;
  logic          af_phase;

  // Shared half-period counter; phase flips on every wrap.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == AW'(AF_HALF - 1)) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt   <= af_cnt + 1'b1;
    end
  end

  // ---------------- player remap ----------------
  if (NP >= 2) begin : g_swap
    // Swap is the first mapping stage, so rotate/autofire follow the swapped channel.
    always_comb begin
      joy_sw = joy_db;
      if (joyswap) begin
        joy_sw[0] = joy_db[1];
        joy_sw[1] = joy_db[0];
      end
    end
  end else begin : g_noswap
    logic unused_joyswap;
    assign unused_joyswap = joyswap;
    assign joy_sw         = joy_db;
  end

  for (genvar p = 0; p < NP; p++) begin : g_player
    mw8080_player_map u_map (
      .btn_in  (joy_sw[p]),
      .rotate  (rotate),
      .af_en   (autofire_en[p]),
      .af_phase(af_phase),
      .btn_out (joy_map[p])
    );
  end

  // ---------------- coin slots ----------------
  logic [NP-1:0] coin_pulse, coin_enter;
  logic [7:0]    coin_inc;

  for (genvar c = 0; c < NP; c++) begin : g_coin
    mw8080_coin_slot #(.COIN_CYCLES(COIN_CYCLES)) u_slot (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .coin_db(coin_db[c]),
      .pulse  (coin_pulse[c]),
      .enter  (coin_enter[c])
    );
  end

  // Simultaneous accepts on several slots are all counted in one cycle.
  always_comb begin
    coin_inc = '0;
    for (int i = 0; i < NP; i++) coin_inc = coin_inc + 8'(coin_enter[i]);
  end

  // ---------------- output registers ----------------
  logic [NP-1:0] start_q;

  // Registered outputs and coin counter (wraps modulo 256).
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      player_q   <= '0;
      start_q    <= '0;
      coin_count <= '0;
    end else begin
      player_q   <= joy_map;
      start_q    <= start_db;
      coin_count <= coin_count + coin_inc;
    end
  end

  // Polarity applied after the registers so reset forces the inactive level at once.
  assign player_out = player_q   ^ {(6*NP){INV}};
  assign start_out  = start_q    ^ {NP{INV}};
  assign coin_out   = coin_pulse ^ {NP{INV}};

endmodule

// File: tb/tb_mw8080_inputs.sv
// Scoreboard bench for mw8080_inputs: timed level expectations and coin
// pulse events are queued by the stimulus and checked by a monitor.
module tb_mw8080_inputs;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [11:0] joy_in = '0;
  logic [1:0]  coin_in = '0, start_in = '0, autofire_en = '0;
  logic        rotate = 1'b0, joyswap = 1'b0;

  logic [11:0] player_out, pl_al;
  logic [1:0]  coin_out, start_out, co_al, st_al;
  logic [7:0]  coin_count, cc_al;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;

  mw8080_inputs #(.NUM_PLAYERS(2), .DB_CYCLES(4), .COIN_CYCLES(10),
                  .AF_HALF(8), .ACTIVE_LOW(0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .joy_in(joy_in), .coin_in(coin_in),
    .start_in(start_in), .rotate(rotate), .joyswap(joyswap),
    .autofire_en(autofire_en), .player_out(player_out), .coin_out(coin_out),
    .start_out(start_out), .coin_count(coin_count));

  mw8080_inputs #(.NUM_PLAYERS(2), .DB_CYCLES(4), .COIN_CYCLES(10),
                  .AF_HALF(8), .ACTIVE_LOW(1)) dut_al (
    .Clk(Clk), .Rst_n(Rst_n), .joy_in(joy_in), .coin_in(coin_in),
    .start_in(start_in), .rotate(rotate), .joyswap(joyswap),
    .autofire_en(autofire_en), .player_out(pl_al), .coin_out(co_al),
    .start_out(st_al), .coin_count(cc_al));

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          sel;
    logic [15:0] mask;
    logic [15:0] val;
    string       name;
  } lvl_t;

  typedef struct {
    logic [1:0] mask;
    int         width;   // -1: pulse cut short by reset
    logic [7:0] count;
  } coin_t;

  lvl_t  lq[$];
  coin_t cq[$];

  function automatic logic [15:0] sel_val(input int s);
    case (s)
      0: return 16'(player_out);
      1: return 16'(coin_count);
      2: return 16'(start_out);
      3: return 16'(coin_out);
      4: return 16'(pl_al);
      5: return 16'(cc_al);
      6: return 16'(st_al);
      7: return 16'(co_al);
      default: return 16'h0;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Expect (output & mask) == val at the negedge following 'dly' more posedges.
  task automatic exp_lvl(input int dly, input int sel, input logic [15:0] mask,
                         input logic [15:0] val, input string name);
    lvl_t e;
    e.due = cyc + dly; e.sel = sel; e.mask = mask; e.val = val; e.name = name;
    lq.push_back(e);
  endtask

  task automatic exp_coin(input logic [1:0] m, input int w, input logic [7:0] c);
    coin_t e;
    e.mask = m; e.width = w; e.count = c;
    cq.push_back(e);
  endtask

  // Monitor: timed level checks.
  always @(negedge Clk) begin
    for (int i = lq.size() - 1; i >= 0; i--) begin
      if (lq[i].due == cyc) begin
        checks++;
        if ((sel_val(lq[i].sel) & lq[i].mask) != lq[i].val) begin
          errors++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", lq[i].name,
                   sel_val(lq[i].sel) & lq[i].mask, lq[i].val, cyc);
        end
        lq.delete(i);
      end
    end
  end

  // Monitor: coin pulses, popped from the scoreboard when each pulse ends.
  logic       trk = 1'b0;
  int         wid = 0;
  logic [1:0] pmask;
  logic [7:0] pcount;
  always @(negedge Clk) begin
    if (!trk) begin
      if (coin_out != 2'b00) begin
        trk = 1'b1; wid = 1; pmask = coin_out; pcount = coin_count;
      end
    end else if (coin_out != 2'b00 && Rst_n) begin
      wid++;
    end else begin
      trk = 1'b0;
      if (!Rst_n) wid = -1;
      checks++;
      if (cq.size() == 0) begin
        errors++;
        $display("FAIL coin_unexpected: got pulse mask %b width %0d expected none", pmask, wid);
      end else begin
        coin_t e;
        e = cq.pop_front();
        if (pmask != e.mask || wid != e.width || pcount != e.count) begin
          errors++;
          $display("FAIL coin_pulse: got mask %b width %0d count %0d expected mask %b width %0d count %0d",
                   pmask, wid, pcount, e.mask, e.width, e.count);
        end
      end
    end
  end

  initial begin
    // Reset state on both polarities.
    step(3);
    exp_lvl(0, 0, 16'hfff, 16'h000, "rst_player");
    exp_lvl(0, 1, 16'h0ff, 16'h000, "rst_count");
    exp_lvl(0, 2, 16'h003, 16'h000, "rst_start");
    exp_lvl(0, 3, 16'h003, 16'h000, "rst_coin");
    exp_lvl(0, 4, 16'hfff, 16'hfff, "rst_al_player");
    exp_lvl(0, 7, 16'h003, 16'h003, "rst_al_coin");
    exp_lvl(0, 6, 16'h003, 16'h003, "rst_al_start");
    step(1);
    Rst_n = 1'b1;
    rel_cyc = cyc;
    step(2);

    // Up held plus start 1: latency 10..13 cycles.
    joy_in[3] = 1'b1; start_in[1] = 1'b1;
    exp_lvl(9, 0, 16'hfff, 16'h000, "up_early");
    exp_lvl(13, 0, 16'hfff, 16'h008, "up_held");
    exp_lvl(13, 2, 16'h003, 16'h002, "start_held");
    exp_lvl(13, 6, 16'h003, 16'h001, "al_start_held");
    exp_lvl(13, 4, 16'hfff, 16'hff7, "al_up_held");
    step(20);
    joy_in[3] = 1'b0; start_in[1] = 1'b0;
    exp_lvl(13, 0, 16'hfff, 16'h000, "up_release");
    exp_lvl(13, 2, 16'h003, 16'h000, "start_release");
    step(20);

    // Glitch spanning at most one sample tick is ignored.
    joy_in[2] = 1'b1;
    exp_lvl(6, 0, 16'hfff, 16'h000, "glitch_a");
    exp_lvl(12, 0, 16'hfff, 16'h000, "glitch_b");
    exp_lvl(20, 0, 16'hfff, 16'h000, "glitch_c");
    step(3);
    joy_in[2] = 1'b0;
    step(25);

    // Rotate: right becomes up; mapping changes show one cycle later.
    rotate = 1'b1; joy_in[0] = 1'b1;
    exp_lvl(9, 0, 16'hfff, 16'h000, "rot_early");
    exp_lvl(13, 0, 16'hfff, 16'h008, "rot_right_to_up");
    step(20);
    rotate = 1'b0;
    exp_lvl(0, 0, 16'hfff, 16'h008, "rot_off_hold");
    exp_lvl(1, 0, 16'hfff, 16'h001, "rot_off_next");
    step(5);
    joyswap = 1'b1;
    exp_lvl(0, 0, 16'hfff, 16'h001, "swap_hold");
    exp_lvl(1, 0, 16'hfff, 16'h040, "swap_ch1");
    step(5);
    joy_in = '0; joyswap = 1'b0;
    exp_lvl(1, 0, 16'hfff, 16'h001, "unswap_next");
    exp_lvl(13, 0, 16'hfff, 16'h000, "right_release");
    step(20);

    // Autofire: fireA follows the 8-cycle phase from reset release.
    autofire_en[0] = 1'b1; joy_in[4] = 1'b1;
    for (int d = 16; d < 40; d++) begin
      int e;
      e = cyc + d;
      exp_lvl(d, 0, 16'h010, (((e - 1 - rel_cyc) / 8) % 2) != 0 ? 16'h010 : 16'h000, "af_phase");
    end
    step(40);
    autofire_en[0] = 1'b0;
    exp_lvl(1, 0, 16'h010, 16'h010, "af_off_a");
    exp_lvl(5, 0, 16'h010, 16'h010, "af_off_b");
    exp_lvl(9, 0, 16'h010, 16'h010, "af_off_c");
    step(12);
    joy_in[4] = 1'b0;
    step(20);

    // Single coin held 200 cycles: one 10-cycle pulse, count 1.
    coin_in[0] = 1'b1;
    exp_coin(2'b01, 10, 8'd1);
    exp_lvl(9, 1, 16'h0ff, 16'h000, "coin_count_early");
    step(200);
    coin_in[0] = 1'b0;
    step(20);
    exp_lvl(0, 1, 16'h0ff, 16'h001, "coin_count_one");

    // Simultaneous coins, +2 each, through the 255 -> 1 wrap.
    for (int i = 0; i < 128; i++) begin
      if (i == 127) exp_lvl(0, 1, 16'h0ff, 16'h0ff, "coin_count_255");
      coin_in = 2'b11;
      exp_coin(2'b11, 10, 8'(1 + 2 * (i + 1)));
      step(30);
      coin_in = 2'b00;
      step(20);
    end
    exp_lvl(0, 1, 16'h0ff, 16'h001, "coin_count_wrap");
    step(1);

    // Reset mid-pulse: outputs inactive at once, held coin counts once after.
    coin_in[0] = 1'b1;
    exp_coin(2'b01, -1, 8'd2);
    exp_coin(2'b01, 10, 8'd1);
    step(15);
    Rst_n = 1'b0;
    exp_lvl(0, 3, 16'h003, 16'h000, "mid_rst_coin");
    exp_lvl(0, 1, 16'h0ff, 16'h000, "mid_rst_count");
    exp_lvl(0, 4, 16'hfff, 16'hfff, "mid_rst_al_player");
    exp_lvl(0, 7, 16'h003, 16'h003, "mid_rst_al_coin");
    exp_lvl(0, 6, 16'h003, 16'h003, "mid_rst_al_start");
    exp_lvl(0, 5, 16'h0ff, 16'h000, "mid_rst_al_count");
    step(3);
    Rst_n = 1'b1;
    exp_lvl(9, 1, 16'h0ff, 16'h000, "post_rst_count_early");
    step(30);
    coin_in[0] = 1'b0;
    exp_lvl(0, 1, 16'h0ff, 16'h001, "post_rst_count");
    exp_lvl(0, 5, 16'h0ff, 16'h001, "post_rst_al_count");
    step(20);

    // Anything still queued never happened.
    step(3);
    foreach (lq[i]) begin
      checks++; errors++;
      $display("FAIL %s: got no sample expected %h (due %0d)", lq[i].name, lq[i].val, lq[i].due);
    end
    foreach (cq[i]) begin
      checks++; errors++;
      $display("FAIL coin_missing: got no pulse expected mask %b width %0d", cq[i].mask, cq[i].width);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
